// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg -- shared definitions for the multi-cycle MIPS-style ALU.
// Holds the 4-bit opcode encodings (unchanged from the single-cycle ALU),
// the 2-bit sequencer state encoding, the divide-by-zero quotient fill bit,
// and a helper that classifies multi-cycle opcodes.
package mips_alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_NOR   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_LUI   = 4'b0101;
    localparam logic [3:0] OP_MULTU = 4'b0110;
    localparam logic [3:0] OP_DIVU  = 4'b0111;
    localparam logic [3:0] OP_SRL   = 4'b1110;
    localparam logic [3:0] OP_SLL   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Quotient on divide by zero is every bit set to this value.
    localparam logic DIVZ_Q_BIT = 1'b1;

    // True for opcodes that run on the iterative engine.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mips_seq_alu_if.sv
// mips_seq_alu_if -- request/response bundle of the sequential ALU.
// master: issues in_valid/ALUOperation/A/B/shamt, observes results.
// slave : the ALU; drives in_ready, out_valid, ALUResult, Zero, HI, LO, busy
//         (and Overflow when ALU_OVERFLOW_EN is defined).
interface mips_seq_alu_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) ();
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         ALUOperation;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic [WIDTH-1:0]   ALUResult;
    logic               Zero;
    logic [WIDTH-1:0]   HI;
    logic [WIDTH-1:0]   LO;
    logic               busy;
`ifdef ALU_OVERFLOW_EN
    logic               Overflow;
`endif

    modport master (
        output in_valid, ALUOperation, A, B, shamt,
        input  in_ready, out_valid, ALUResult, Zero, HI, LO, busy
`ifdef ALU_OVERFLOW_EN
        , input Overflow
`endif
    );

    modport slave (
        input  in_valid, ALUOperation, A, B, shamt,
        output in_ready, out_valid, ALUResult, Zero, HI, LO, busy
`ifdef ALU_OVERFLOW_EN
        , output Overflow
`endif
    );
endinterface

// File: rtl/mips_alu_muldiv.sv
// mips_alu_muldiv -- iterative unsigned multiply / restoring divide engine.
// Ports: clk, reset (sync, active-high), start (load operands), op_div
// (1 = DIVU, 0 = MULTU), a/b operands, done (high in the cycle whose edge
// completes the operation), fin_lo (LO value being written at that edge),
// hi/lo registered results that change only at completion.
module mips_alu_muldiv
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] fin_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic                 running_r;
    logic                 op_div_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]     opnd_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;

    logic [2*WIDTH-1:0]   step_acc_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH:0]       trial_s;
    logic [WIDTH:0]       diff_s;
    logic                 divz_s;

    // One iteration: shift-add for multiply, shift-subtract for divide.
    // Both leave the high half in acc[2W-1:W] (HI) and low half in acc[W-1:0] (LO).
    always_comb begin
        step_acc_s = acc_r;
        sum_s      = '0;
        trial_s    = '0;
        diff_s     = '0;
        if (op_div_r) begin
            // Partial remainder shifted left with the next dividend bit; the
            // extra bit keeps the compare exact for divisors near 2^WIDTH.
            trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
            diff_s  = trial_s - {1'b0, opnd_r};
            if (!diff_s[WIDTH]) begin
                step_acc_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                step_acc_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Carry bit of the add is shifted straight into the product.
            sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                         (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
            step_acc_s = {sum_s, acc_r[WIDTH-1:1]};
        end
    end

    assign divz_s = op_div_r && (opnd_r == {WIDTH{1'b0}});
    assign done   = running_r && (cnt_r == CNT_W'(1));
    assign fin_lo = divz_s ? {WIDTH{DIVZ_Q_BIT}} : step_acc_s[WIDTH-1:0];
    assign hi     = hi_r;
    assign lo     = lo_r;

    // Operand load, iteration counter and HI/LO commit at the final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            running_r <= 1'b0;
            op_div_r  <= 1'b0;
            cnt_r     <= '0;
            acc_r     <= '0;
            opnd_r    <= '0;
            hi_r      <= '0;
            lo_r      <= '0;
        end else if (start) begin
            running_r <= 1'b1;
            op_div_r  <= op_div;
            cnt_r     <= CNT_W'(WIDTH);
            opnd_r    <= op_div ? b : a;
            acc_r     <= {{WIDTH{1'b0}}, (op_div ? a : b)};
        end else if (running_r) begin
            acc_r <= step_acc_s;
            cnt_r <= cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
                running_r <= 1'b0;
                hi_r      <= step_acc_s[2*WIDTH-1:WIDTH];
                lo_r      <= fin_lo;
            end
        end
    end

endmodule

// File: rtl/mips_seq_alu.sv
// mips_seq_alu -- multi-cycle execute-stage ALU with valid/ready handshake.
// Ports: clk, reset (synchronous, active-high), bus (mips_seq_alu_if.slave):
//   in_valid/in_ready request handshake, ALUOperation/A/B/shamt operands,
//   out_valid one-cycle result pulse, ALUResult/Zero registered result,
//   HI/LO multiply/divide results, busy while MULTU/DIVU iterate.
// Optional macro ALU_OVERFLOW_EN adds the registered Overflow output for
// signed ADD/SUB overflow.
module mips_seq_alu
    import mips_alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SHAMT_W   = $clog2(WIDTH),
    parameter int LUI_SHIFT = WIDTH / 2
) (
    input  logic          clk,
    input  logic          reset,
    mips_seq_alu_if.slave bus
);
    state_t           state_r;
    state_t           next_state_s;
    logic             accept_s;
    logic             start_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             md_done_s;
    logic [WIDTH-1:0] md_fin_lo_s;
    logic [WIDTH-1:0] md_hi_s;
    logic [WIDTH-1:0] md_lo_s;

    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic             busy_r;
`ifdef ALU_OVERFLOW_EN
    logic             ovf_s;
    logic             ovf_r;
`endif

    assign accept_s = bus.in_valid && (state_r == ST_IDLE);
    assign start_s  = accept_s && is_long_op(bus.ALUOperation);

    mips_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (start_s),
        .op_div (bus.ALUOperation == OP_DIVU),
        .a      (bus.A),
        .b      (bus.B),
        .done   (md_done_s),
        .fin_lo (md_fin_lo_s),
        .hi     (md_hi_s),
        .lo     (md_lo_s)
    );

    // Single-cycle result datapath.
    always_comb begin
        alu_res_s = '0;
        case (bus.ALUOperation)
            OP_AND:  alu_res_s = bus.A & bus.B;
            OP_OR:   alu_res_s = bus.A | bus.B;
            OP_NOR:  alu_res_s = ~(bus.A | bus.B);
            OP_ADD:  alu_res_s = bus.A + bus.B;
            OP_SUB:  alu_res_s = bus.A - bus.B;
            OP_LUI:  alu_res_s = bus.B << LUI_SHIFT;
            OP_SRL:  alu_res_s = bus.B >> bus.shamt;
            OP_SLL:  alu_res_s = bus.B << bus.shamt;
            default: alu_res_s = '0;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    // Signed overflow detection for ADD/SUB from operand and result signs.
    always_comb begin
        ovf_s = 1'b0;
        case (bus.ALUOperation)
            OP_ADD:  ovf_s = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                             (alu_res_s[WIDTH-1] != bus.A[WIDTH-1]);
            OP_SUB:  ovf_s = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                             (alu_res_s[WIDTH-1] != bus.A[WIDTH-1]);
            default: ovf_s = 1'b0;
        endcase
    end
`endif

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (bus.ALUOperation == OP_MULTU) begin
                        next_state_s = ST_MUL;
                    end else if (bus.ALUOperation == OP_DIVU) begin
                        next_state_s = ST_DIV;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (md_done_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Result registers and status flags decoded from the upcoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_r    <= '0;
            zero_r      <= 1'b1;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            ovf_r       <= 1'b0;
`endif
        end else begin
            out_valid_r <= (next_state_s == ST_DONE);
            in_ready_r  <= (next_state_s == ST_IDLE);
            busy_r      <= (next_state_s == ST_MUL) || (next_state_s == ST_DIV);
            if (accept_s && !is_long_op(bus.ALUOperation)) begin
                result_r <= alu_res_s;
                zero_r   <= (alu_res_s == {WIDTH{1'b0}});
`ifdef ALU_OVERFLOW_EN
                ovf_r    <= ovf_s;
`endif
            end else if (md_done_s) begin
                result_r <= md_fin_lo_s;
                zero_r   <= (md_fin_lo_s == {WIDTH{1'b0}});
`ifdef ALU_OVERFLOW_EN
                ovf_r    <= 1'b0;
`endif
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.ALUResult = result_r;
    assign bus.Zero      = zero_r;
    assign bus.HI        = md_hi_s;
    assign bus.LO        = md_lo_s;
    assign bus.busy      = busy_r;
`ifdef ALU_OVERFLOW_EN
    assign bus.Overflow  = ovf_r;
`endif

endmodule

// File: tb/tb_mips_seq_alu.sv
// tb_mips_seq_alu -- directed self-checking bench for mips_seq_alu (WIDTH=32).
module tb_mips_seq_alu;
    import mips_alu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   lat;
    int   busy_cyc;

    mips_seq_alu_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    mips_seq_alu #(.WIDTH(32), .SHAMT_W(5), .LUI_SHIFT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        bus.in_valid     = 1'b1;
        bus.ALUOperation = op;
        bus.A            = a;
        bus.B            = b;
        bus.shamt        = sh;
        tick();
        bus.in_valid     = 1'b0;
    endtask

    // Latency counted from the accept cycle; bounded at 100 cycles.
    task automatic wait_out(output int l, output int bc);
        l  = 1;
        bc = 0;
        while (!bus.out_valid && l < 100) begin
            if (bus.busy) bc++;
            tick();
            l++;
        end
    endtask

    initial begin
        bus.in_valid     = 1'b0;
        bus.ALUOperation = OP_AND;
        bus.A            = 32'h0;
        bus.B            = 32'h0;
        bus.shamt        = 5'd0;
        reset            = 1'b1;
        tick();
        // in_valid during reset must not be accepted
        bus.in_valid     = 1'b1;
        bus.ALUOperation = OP_ADD;
        bus.A            = 32'd1;
        bus.B            = 32'd1;
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        check("rst_result",   {32'h0, bus.ALUResult}, 64'h0);
        check("rst_zero",     {63'h0, bus.Zero}, 64'h1);
        check("rst_hilo",     {bus.HI, bus.LO}, 64'h0);
        check("rst_in_ready", {63'h0, bus.in_ready}, 64'h1);
        check("rst_out_valid",{63'h0, bus.out_valid}, 64'h0);
        check("rst_busy",     {63'h0, bus.busy}, 64'h0);
        tick();
        check("rst_no_accept",{63'h0, bus.out_valid}, 64'h0);

        // ADD wraps to zero
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 5'd0);
        wait_out(lat, busy_cyc);
        check("add_latency", 64'(lat), 64'd1);
        check("add_result",  {32'h0, bus.ALUResult}, 64'h0);
        check("add_zero",    {63'h0, bus.Zero}, 64'h1);
        check("add_in_ready_done", {63'h0, bus.in_ready}, 64'h0);
`ifdef ALU_OVERFLOW_EN
        check("add_ovf",     {63'h0, bus.Overflow}, 64'h0);
`endif
        tick();
        check("add_pulse_end", {63'h0, bus.out_valid}, 64'h0);
        check("add_in_ready",  {63'h0, bus.in_ready}, 64'h1);

        issue(OP_SUB, 32'h8000_0000, 32'h1, 5'd0);
        check("sub_result", {32'h0, bus.ALUResult}, 64'h7FFF_FFFF);
        check("sub_zero",   {63'h0, bus.Zero}, 64'h0);
`ifdef ALU_OVERFLOW_EN
        check("sub_ovf",    {63'h0, bus.Overflow}, 64'h1);
`endif
        tick();
        issue(OP_LUI, 32'h0000_1234, 32'h0000_1234, 5'd0);
        check("lui", {32'h0, bus.ALUResult}, 64'h1234_0000);
        tick();
        issue(OP_SLL, 32'h0, 32'h1, 5'd31);
        check("sll", {32'h0, bus.ALUResult}, 64'h8000_0000);
        tick();
        issue(OP_SRL, 32'h0, 32'h8000_0000, 5'd31);
        check("srl", {32'h0, bus.ALUResult}, 64'h1);
        tick();
        issue(OP_NOR, 32'h0F0F_0000, 32'h0000_00FF, 5'd0);
        check("nor", {32'h0, bus.ALUResult}, 64'hF0F0_FF00);
        tick();
        issue(OP_OR, 32'h1200_0000, 32'h0000_0034, 5'd0);
        check("or", {32'h0, bus.ALUResult}, 64'h1200_0034);
        tick();
        issue(4'b1000, 32'h5, 32'h5, 5'd0);
        check("undef_op", {32'h0, bus.ALUResult}, 64'h0);
        check("undef_zero", {63'h0, bus.Zero}, 64'h1);
        check("hilo_held_single", {bus.HI, bus.LO}, 64'h0);
        tick();

        // MULTU with in_valid held high (and operands changing) while busy
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        lat      = 1;
        busy_cyc = 0;
        bus.in_valid     = 1'b1;
        bus.ALUOperation = OP_ADD;
        bus.A            = 32'd3;
        bus.B            = 32'd4;
        while (!bus.out_valid && lat < 100) begin
            if (bus.busy) busy_cyc++;
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
        check("mul_latency", 64'(lat), 64'd33);
        check("mul_busy_cycles", 64'(busy_cyc), 64'd32);
        check("mul_hilo", {bus.HI, bus.LO}, 64'hFFFF_FFFE_0000_0001);
        check("mul_result", {32'h0, bus.ALUResult}, 64'h1);
        check("mul_busy_done", {63'h0, bus.busy}, 64'h0);
        tick();
        check("mul_no_queued_op", {63'h0, bus.out_valid}, 64'h0);
        check("mul_result_kept", {32'h0, bus.ALUResult}, 64'h1);

        issue(OP_DIVU, 32'd100, 32'd7, 5'd0);
        wait_out(lat, busy_cyc);
        check("div_latency", 64'(lat), 64'd33);
        check("div_hilo", {bus.HI, bus.LO}, {32'd2, 32'd14});
        check("div_result", {32'h0, bus.ALUResult}, 64'd14);
        tick();
        issue(OP_DIVU, 32'd5, 32'd0, 5'd0);
        wait_out(lat, busy_cyc);
        check("divz_latency", 64'(lat), 64'd33);
        check("divz_hilo", {bus.HI, bus.LO}, {32'd5, 32'hFFFF_FFFF});
        check("divz_result", {32'h0, bus.ALUResult}, 64'hFFFF_FFFF);
        tick();

        // Reset 10 cycles into a MULTU discards it and clears HI/LO
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 5'd0);
        for (int i = 0; i < 9; i++) tick();
        check("midrst_busy_before", {63'h0, bus.busy}, 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", {63'h0, bus.busy}, 64'h0);
        check("midrst_in_ready", {63'h0, bus.in_ready}, 64'h1);
        check("midrst_hilo", {bus.HI, bus.LO}, 64'h0);
        check("midrst_result", {31'h0, bus.Zero, bus.ALUResult}, 64'h1_0000_0000);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) lat++;
            tick();
        end
        check("midrst_no_out_valid", 64'(lat), 64'd0);
        issue(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 5'd0);
        check("and_after_rst_valid", {63'h0, bus.out_valid}, 64'h1);
        check("and_after_rst", {32'h0, bus.ALUResult}, 64'h0000_00F0);
        check("and_hilo_zero", {bus.HI, bus.LO}, 64'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
